// File: rtl/seg_arbiter.sv
// Debounced 5-button round-robin arbiter for a shared seven-segment display.
// Define SEG_ARB_FIXED_PRIORITY_EN to select fixed priority (lowest index wins).
module seg_arbiter #(
    parameter int unsigned DEBOUNCE_CYCLES = 4,
    parameter int unsigned HOLD_CYCLES     = 8
) (
    input  logic       clk_clk,
    input  logic       reset_reset_n,
    input  logic [4:0] button_req,
    output logic [4:0] grant,
    output logic       busy,
    output logic [6:0] sevseg_owner,
    output logic [6:0] sevseg_count,
    output logic [1:0] fsm_state
);

    // Handshake: there is none; a request is a debounced rising edge, remembered
    // in pending[] until served, and a grant is a fixed-length one-hot window.

    localparam logic [7:0] DEB_LAST  = 8'(DEBOUNCE_CYCLES - 1);
    localparam logic [7:0] HOLD_LOAD = 8'(HOLD_CYCLES);
    localparam logic [6:0] SEG_BLANK = 7'h7F;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        GRANT   = 2'd1,
        RELEASE = 2'd2
    } state_t;

    state_t     state, state_next;
    logic [4:0] sync1, sync2;
    logic [4:0] deb, deb_prev;
    logic [7:0] deb_cnt [5];
    logic [4:0] rise;
    logic [4:0] pending, pending_next, clear_mask;
    logic [7:0] hold_cnt, hold_next;
    logic [2:0] owner, owner_next, winner;
    logic       win_valid;
    logic [3:0] grant_count, count_next;
    logic [4:0] grant_next;
`ifndef SEG_ARB_FIXED_PRIORITY_EN
    logic [2:0] last_owner;
`endif

    function automatic logic [6:0] seg_digit(input logic [3:0] d);
        case (d)
            4'd0:    seg_digit = 7'h40;
            4'd1:    seg_digit = 7'h79;
            4'd2:    seg_digit = 7'h24;
            4'd3:    seg_digit = 7'h30;
            4'd4:    seg_digit = 7'h19;
            4'd5:    seg_digit = 7'h12;
            4'd6:    seg_digit = 7'h02;
            4'd7:    seg_digit = 7'h78;
            4'd8:    seg_digit = 7'h00;
            4'd9:    seg_digit = 7'h10;
            default: seg_digit = SEG_BLANK;
        endcase
    endfunction

    always_ff @(posedge clk_clk) begin
        if (!reset_reset_n) begin
            sync1 <= '0;
            sync2 <= '0;
        end else begin
            sync1 <= button_req;
            sync2 <= sync1;
        end
    end

    // The debounced level flips on the DEBOUNCE_CYCLES-th consecutive mismatch.
    always_ff @(posedge clk_clk) begin
        if (!reset_reset_n) begin
            deb      <= '0;
            deb_prev <= '0;
            for (int i = 0; i < 5; i++) deb_cnt[i] <= '0;
        end else begin
            deb_prev <= deb;
            for (int i = 0; i < 5; i++) begin
                if (sync2[i] != deb[i]) begin
                    if (deb_cnt[i] >= DEB_LAST) begin
                        deb[i]     <= ~deb[i];
                        deb_cnt[i] <= '0;
                    end else begin
                        deb_cnt[i] <= deb_cnt[i] + 8'd1;
                    end
                end else begin
                    deb_cnt[i] <= '0;
                end
            end
        end
    end

    assign rise = deb & ~deb_prev;

    always_comb begin
        win_valid = 1'b0;
        winner    = 3'd0;
`ifdef SEG_ARB_FIXED_PRIORITY_EN
        for (int i = 4; i >= 0; i--) begin
            if (pending[i]) begin
                win_valid = 1'b1;
                winner    = 3'(i);
            end
        end
`else
        for (int k = 1; k <= 5; k++) begin
            if (!win_valid && pending[3'((int'(last_owner) + k) % 5)]) begin
                win_valid = 1'b1;
                winner    = 3'((int'(last_owner) + k) % 5);
            end
        end
`endif
    end

    always_comb begin
        state_next = state;
        hold_next  = hold_cnt;
        owner_next = owner;
        count_next = grant_count;
        grant_next = '0;
        clear_mask = '0;
        case (state)
            IDLE: begin
                if (win_valid) begin
                    state_next = GRANT;
                    hold_next  = HOLD_LOAD;
                    owner_next = winner;
                    clear_mask = 5'b1 << winner;
                    grant_next = 5'b1 << winner;
                    count_next = (grant_count == 4'd9) ? 4'd0 : grant_count + 4'd1;
                end
            end
            GRANT: begin
                if (hold_cnt <= 8'd1) begin
                    state_next = RELEASE;
                end else begin
                    hold_next  = hold_cnt - 8'd1;
                    grant_next = 5'b1 << owner;
                end
            end
            RELEASE: state_next = IDLE;
            default: state_next = IDLE;
        endcase
        // An edge arriving while already pending is absorbed.
        pending_next = (pending | rise) & ~clear_mask;
    end

    always_ff @(posedge clk_clk) begin
        if (!reset_reset_n) begin
            state        <= IDLE;
            hold_cnt     <= '0;
            owner        <= '0;
            grant_count  <= '0;
            pending      <= '0;
            grant        <= '0;
            busy         <= 1'b0;
            sevseg_owner <= SEG_BLANK;
            sevseg_count <= 7'h40;
        end else begin
            state        <= state_next;
            hold_cnt     <= hold_next;
            owner        <= owner_next;
            grant_count  <= count_next;
            pending      <= pending_next;
            grant        <= grant_next;
            busy         <= |grant_next;
            sevseg_owner <= (state_next == GRANT) ? seg_digit({1'b0, owner_next}) : SEG_BLANK;
            sevseg_count <= seg_digit(count_next);
        end
    end

`ifndef SEG_ARB_FIXED_PRIORITY_EN
    always_ff @(posedge clk_clk) begin
        if (!reset_reset_n) begin
            last_owner <= 3'd4;
        end else if (state == IDLE && win_valid) begin
            last_owner <= winner;
        end
    end
`endif

    assign fsm_state = state;

endmodule

// File: tb/tb_seg_arbiter.sv
// Bench for seg_arbiter: directed vector table, multi-cycle arbitration
// sequences, and randomized button traffic against a behavioural model.
module tb_seg_arbiter;
    localparam int D = 4;
    localparam int H = 8;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [4:0] btn = '0;
    logic [4:0] grant;
    logic       busy;
    logic [6:0] seg_owner, seg_count;
    logic [1:0] fsm_state;

    int checks = 0;
    int failures = 0;

    logic [6:0] seg_tab [10] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19,
                                 7'h12, 7'h02, 7'h78, 7'h00, 7'h10};

    seg_arbiter #(.DEBOUNCE_CYCLES(D), .HOLD_CYCLES(H)) dut (
        .clk_clk      (clk),
        .reset_reset_n(rst_n),
        .button_req   (btn),
        .grant        (grant),
        .busy         (busy),
        .sevseg_owner (seg_owner),
        .sevseg_count (seg_count),
        .fsm_state    (fsm_state)
    );

    always #5 clk = ~clk;

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Behavioural model: pipeline delay, run-length debounce, pending set,
    // and a grant window tracked as a remaining-cycle count.
    logic [4:0] m_s1 = '0, m_s2 = '0, m_deb = '0, m_prev = '0, m_pend = '0;
    int         m_run [5] = '{0, 0, 0, 0, 0};
    int         m_left = 0;
    bit         m_gap = 1'b0;
    int         m_owner = 0, m_last = 4, m_gc = 0;
    logic [4:0] o_s1, o_s2, o_deb, o_prev, o_pend, n_pend;
    int         w;

    always @(posedge clk) begin
        if (!rst_n) begin
            m_s1 = '0; m_s2 = '0; m_deb = '0; m_prev = '0; m_pend = '0;
            for (int i = 0; i < 5; i++) m_run[i] = 0;
            m_left = 0; m_gap = 1'b0; m_owner = 0; m_last = 4; m_gc = 0;
        end else begin
            o_s1 = m_s1; o_s2 = m_s2; o_deb = m_deb; o_prev = m_prev; o_pend = m_pend;
            m_s1 = btn;
            m_s2 = o_s1;
            for (int i = 0; i < 5; i++) begin
                if (o_s2[i] != o_deb[i]) begin
                    m_run[i]++;
                    if (m_run[i] >= D) begin
                        m_deb[i] = o_s2[i];
                        m_run[i] = 0;
                    end
                end else begin
                    m_run[i] = 0;
                end
            end
            m_prev = o_deb;
            n_pend = o_pend | (o_deb & ~o_prev);
            if (m_left > 0) begin
                m_left--;
                if (m_left == 0) m_gap = 1'b1;
            end else if (m_gap) begin
                m_gap = 1'b0;
            end else if (o_pend != 0) begin
                w = -1;
`ifdef SEG_ARB_FIXED_PRIORITY_EN
                for (int i = 0; i < 5; i++) if (w < 0 && o_pend[i]) w = i;
`else
                for (int k = 1; k <= 5; k++) if (w < 0 && o_pend[(m_last + k) % 5]) w = (m_last + k) % 5;
`endif
                m_owner = w;
                m_last = w;
                n_pend[w] = 1'b0;
                m_left = H;
                m_gc = (m_gc + 1) % 10;
            end
            m_pend = n_pend;
        end
    end

    typedef struct {
        logic       rst_n;
        logic [4:0] btn;
        logic [4:0] grant;
        logic       busy;
        logic [6:0] owner;
        logic [6:0] count;
    } vec_t;

    vec_t vt[$];

    task automatic add_vec(input int n, input logic r, input logic [4:0] b, input logic [4:0] g,
                           input logic bz, input logic [6:0] o, input logic [6:0] c);
        vec_t v;
        v.rst_n = r; v.btn = b; v.grant = g; v.busy = bz; v.owner = o; v.count = c;
        for (int i = 0; i < n; i++) vt.push_back(v);
    endtask

    task automatic wait_grant(input int bound, output logic [4:0] g);
        int n = 0;
        while (grant == 0 && n < bound) begin
            step();
            n++;
        end
        check("wait_grant_timeout", 32'(grant != 0), 32'd1);
        g = grant;
    endtask

    task automatic hold_len(input logic [4:0] g, output int hi);
        hi = 1;
        while (hi < 100) begin
            step();
            if (grant !== g) break;
            hi++;
        end
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        btn = '0;
        step();
        step();
        rst_n = 1'b1;
    endtask

    logic [4:0] g1, g2, exp_first, exp_second, exp_g;
    logic [6:0] exp_own;
    int         hi, gap, tmr [5];
    bit         saw_grant;

    initial begin
        // Reset with all buttons pressed, then a single press of button 2, then a short glitch on button 1.
        add_vec(2, 1'b0, 5'h1F, 5'h00, 1'b0, 7'h7F, 7'h40);
        add_vec(1, 1'b1, 5'h00, 5'h00, 1'b0, 7'h7F, 7'h40);
        add_vec(1, 1'b0, 5'h00, 5'h00, 1'b0, 7'h7F, 7'h40);
        add_vec(7, 1'b1, 5'h04, 5'h00, 1'b0, 7'h7F, 7'h40);
        add_vec(5, 1'b1, 5'h04, 5'h04, 1'b1, 7'h24, 7'h79);
        add_vec(3, 1'b1, 5'h00, 5'h04, 1'b1, 7'h24, 7'h79);
        add_vec(2, 1'b1, 5'h00, 5'h00, 1'b0, 7'h7F, 7'h79);
        add_vec(3, 1'b1, 5'h02, 5'h00, 1'b0, 7'h7F, 7'h79);
        add_vec(8, 1'b1, 5'h00, 5'h00, 1'b0, 7'h7F, 7'h79);

        for (int i = 0; i < vt.size(); i++) begin
            rst_n = vt[i].rst_n;
            btn = vt[i].btn;
            step();
            check($sformatf("vec%0d_grant", i), 32'(grant), 32'(vt[i].grant));
            check($sformatf("vec%0d_busy", i), 32'(busy), 32'(vt[i].busy));
            check($sformatf("vec%0d_owner", i), 32'(seg_owner), 32'(vt[i].owner));
            check($sformatf("vec%0d_count", i), 32'(seg_count), 32'(vt[i].count));
        end

        // Last owner is 2; buttons 1 and 3 pressed together.
`ifdef SEG_ARB_FIXED_PRIORITY_EN
        exp_first = 5'h02; exp_second = 5'h08;
`else
        exp_first = 5'h08; exp_second = 5'h02;
`endif
        btn = 5'b01010;
        wait_grant(40, g1);
        btn = '0;
        check("tie_first_grant", 32'(g1), 32'(exp_first));
        check("tie_first_count", 32'(seg_count), 32'(seg_tab[2]));
        hold_len(g1, hi);
        check("tie_first_hold", 32'(hi), 32'(H));
        gap = 0;
        while (grant == 0 && gap < 100) begin
            gap++;
            step();
        end
        check("tie_gap", 32'(gap), 32'd2);
        check("tie_second_grant", 32'(grant), 32'(exp_second));
        check("tie_second_count", 32'(seg_count), 32'(seg_tab[3]));
        hold_len(grant, hi);
        check("tie_second_hold", 32'(hi), 32'(H));

        // Ten rounds from reset: count display wraps back to 0.
        do_reset();
        for (int k = 0; k < 10; k++) begin
            btn = 5'(1 << (k % 5));
            wait_grant(40, g2);
            btn = '0;
            check($sformatf("round%0d_grant", k), 32'(g2), 32'(1 << (k % 5)));
            check($sformatf("round%0d_owner", k), 32'(seg_owner), 32'(seg_tab[k % 5]));
            check($sformatf("round%0d_count", k), 32'(seg_count), 32'(seg_tab[(k + 1) % 10]));
            hold_len(g2, hi);
            check($sformatf("round%0d_hold", k), 32'(hi), 32'(H));
            for (int j = 0; j < 4; j++) step();
        end

        // Reset during the fourth grant cycle drops the grant and discards it.
        do_reset();
        btn = 5'h01;
        wait_grant(40, g1);
        btn = '0;
        step(); step(); step();
        check("midreset_pre_grant", 32'(grant), 32'h01);
        rst_n = 1'b0;
        step();
        check("midreset_grant", 32'(grant), 32'h00);
        check("midreset_busy", 32'(busy), 32'd0);
        check("midreset_owner", 32'(seg_owner), 32'h7F);
        check("midreset_count", 32'(seg_count), 32'h40);
        rst_n = 1'b1;
        saw_grant = 1'b0;
        for (int j = 0; j < 30; j++) begin
            step();
            if (grant != 0) saw_grant = 1'b1;
        end
        check("midreset_no_regrant", 32'(saw_grant), 32'd0);

        // Random button traffic with occasional resets, checked against the model every cycle.
        do_reset();
        for (int i = 0; i < 5; i++) tmr[i] = 0;
        for (int c = 0; c < 3000; c++) begin
            for (int i = 0; i < 5; i++) begin
                if (tmr[i] == 0) begin
                    btn[i] = 1'($urandom_range(0, 1));
                    tmr[i] = $urandom_range(1, 14);
                end else begin
                    tmr[i]--;
                end
            end
            rst_n = ($urandom_range(0, 599) != 0);
            step();
            exp_g = (m_left > 0) ? 5'(1 << m_owner) : 5'h00;
            exp_own = (m_left > 0) ? seg_tab[m_owner] : 7'h7F;
            check("rand_grant", 32'(grant), 32'(exp_g));
            check("rand_busy", 32'(busy), 32'(m_left > 0));
            check("rand_owner", 32'(seg_owner), 32'(exp_own));
            check("rand_count", 32'(seg_count), 32'(seg_tab[m_gc]));
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
